prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, fetch address width.
REQ-002 Parameter DATA_W, default 32, instruction word width; a multiple of 8.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; a power of two, at least 2.
REQ-004 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-005 i_clk  in  1  clock; reset i_rst, asynchronous, active-high.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_enable  in  1  permits new memory requests (CPU running flag).
REQ-008 i_flush  in  1  redirect pulse; i_flush_addr  in  ADDR_W  new fetch address.
REQ-009 o_mem_address  out  ADDR_W; o_mem_read  out  1; i_mem_valid  in  1; i_mem_data  in  DATA_W.
REQ-010 i_error_not_present, i_error_not_user  in  1 each  translation faults for the current request.
REQ-011 o_instr_valid  out  1; o_instr  out  DATA_W; o_instr_addr  out  ADDR_W; o_instr_fault  out  2 (bit0 not_present, bit1 not_user); i_instr_ready  in  1.

Function
REQ-012 States: IDLE, REQ (read outstanding), DRAIN (outstanding read to be discarded), HALT (fault queued, no fetching).
REQ-013 IDLE -> REQ when i_enable and count < DEPTH and no i_flush; o_mem_read=1 and o_mem_address=pc from the next edge.
REQ-014 In REQ and DRAIN, o_mem_read and o_mem_address SHALL be held stable until i_mem_valid or either error input is 1.
REQ-015 REQ completion with i_mem_valid: push {i_mem_data, pc, fault=0}; pc <= pc + DATA_W/8, modulo 2^ADDR_W; -> IDLE.
REQ-016 REQ completion with an error input: push {data=0, pc, fault bits}; pc unchanged; -> HALT; errors take priority over i_mem_valid in the same cycle.
REQ-017 o_mem_read SHALL be 0 for at least one cycle between consecutive requests; sustained throughput is one word per two cycles.
REQ-018 Queue head drives o_instr*; the head pops when o_instr_valid and i_instr_ready; push and pop in the same cycle leave count unchanged.
REQ-019 A push is never issued into a full queue: a request is issued only when count < DEPTH, and only one request is outstanding.
REQ-020 Response latency: a word accepted at edge N appears on o_instr_valid after edge N.
REQ-021 i_flush: the queue empties, pc <= i_flush_addr, and the same-cycle pop is ignored; flush wins over every other event.
REQ-022 Flush in REQ with no completion that cycle -> DRAIN; a flush coinciding with completion discards the response -> IDLE.
REQ-023 DRAIN: the completion (valid or error) is discarded, no push -> IDLE; a further flush in DRAIN updates pc only.
REQ-024 HALT is left only by i_flush (-> IDLE); i_enable=0 blocks issue but never aborts an outstanding read.

Reset
REQ-025 i_rst SHALL force: state IDLE, pc=RESET_VECTOR, queue empty, o_mem_read=0, o_mem_address=RESET_VECTOR, o_instr_valid=0, o_instr=0, o_instr_addr=0, o_instr_fault=0.
REQ-026 Reset mid-request SHALL drop the request immediately, and any later i_mem_valid from it SHALL be ignored in IDLE.

Structure
REQ-027 The fetch-state enum and the fault-bit encoding SHALL live in the shared CPU package, next to the instruction typedefs.
REQ-028 The queue SHALL be a sub-module fetch_fifo (parametrised by width and DEPTH, with count output); all control SHALL stay in prefetch_unit.

Verification
REQ-029 Reset, i_enable=1, memory returns 0x11,0x22,0x33 with 1-cycle latency, ready=1 -> instrs at addresses 0x0, 0x4, 0x8 in order; o_mem_read low for at least one cycle between requests.
REQ-030 DEPTH=4, ready=0 -> exactly 4 reads issued, addresses 0x0-0xC; o_mem_read then stays 0; one pop allows exactly one new read at 0x10.
REQ-031 Flush to 0x100 while a read of 0x8 is outstanding with latency 3 -> o_mem_address held at 0x8 until valid; response discarded; next read at 0x100; queue empty after flush.
REQ-032 i_error_not_user on the read of 0x4 -> entry at 0x4 with o_instr_fault=2'b10 after entry 0x0; no further reads until a flush to 0x40, then a read at 0x40.
REQ-033 RESET_VECTOR=0xFFFFFFFC -> second fetch address 0x0 (wrap-around); assert i_rst during REQ -> o_mem_read=0 asynchronously and queue empty.
REQ-034 Simultaneous push and pop at count=DEPTH-1 -> count unchanged and order preserved; simultaneous flush and pop -> queue empty.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared CPU fetch definitions: fetch FSM states, instruction fault encoding
// and a helper that packs translation faults into that encoding.
package prefetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DRAIN,
        FETCH_HALT
    } fetch_state_t;

    localparam int FAULT_NOT_PRESENT_BIT = 0;
    localparam int FAULT_NOT_USER_BIT    = 1;

    typedef logic [1:0] instr_fault_t;

    function automatic instr_fault_t make_fault(input logic not_present, input logic not_user);
        instr_fault_t f;
        f = '0;
        f[FAULT_NOT_PRESENT_BIT] = not_present;
        f[FAULT_NOT_USER_BIT]    = not_user;
        return f;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with occupancy count and synchronous clear.
// Latency: a pushed word is visible at the head after the push edge.
// Backpressure: the caller never pushes when full; clear beats push and pop.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic                     o_vld,
    output logic [WIDTH-1:0]         o_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !i_clear;
    assign do_pop  = i_pop && !i_clear && (count != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_push_dat;
    end

    assign o_vld   = (count != '0);
    assign o_dat   = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: one outstanding read, results queued in fetch_fifo.
// Latency: request one edge after issue decision; response visible after the push edge.
// Backpressure: no new read while the queue is full; i_instr_ready pops the head.
module prefetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_addr,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_read,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_error_not_present,
    input  logic              i_error_not_user,
    output logic              o_instr_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_addr,
    output logic [1:0]        o_instr_fault,
    input  logic              i_instr_ready
);
    import prefetch_unit_pkg::*;

    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam int                EW      = DATA_W + ADDR_W + 2;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] mem_addr, addr_n;
    logic              mem_read, read_n;
    logic              push;
    logic              mem_err;
    logic              complete;
    logic [EW-1:0]     push_dat;
    logic [EW-1:0]     head_dat;
    logic              head_vld;
    logic [CW-1:0]     fifo_count;

    assign mem_err  = i_error_not_present | i_error_not_user;
    assign complete = mem_read && (i_mem_valid || mem_err);
    assign push_dat = {(mem_err ? {DATA_W{1'b0}} : i_mem_data), pc,
                       make_fault(i_error_not_present, i_error_not_user)};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_VECTOR;
            mem_addr <= RESET_VECTOR;
            mem_read <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            mem_addr <= addr_n;
            mem_read <= read_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = mem_addr;
        read_n  = mem_read;
        push    = 1'b0;
        if (i_flush) begin
            pc_n = i_flush_addr;
            // A read still in flight must be waited out, so its answer is dropped in DRAIN.
            if ((state == FETCH_REQ || state == FETCH_DRAIN) && !complete) begin
                state_n = FETCH_DRAIN;
            end else begin
                state_n = FETCH_IDLE;
                read_n  = 1'b0;
            end
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (i_enable && (fifo_count < DEPTH_C)) begin
                        state_n = FETCH_REQ;
                        read_n  = 1'b1;
                        addr_n  = pc;
                    end
                end
                FETCH_REQ: begin
                    if (mem_err) begin
                        push    = 1'b1;
                        state_n = FETCH_HALT;
                        read_n  = 1'b0;
                    end else if (i_mem_valid) begin
                        push    = 1'b1;
                        pc_n    = pc + STEP;
                        state_n = FETCH_IDLE;
                        read_n  = 1'b0;
                    end
                end
                FETCH_DRAIN: begin
                    if (complete) begin
                        state_n = FETCH_IDLE;
                        read_n  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_flush),
        .i_push     (push),
        .i_push_dat (push_dat),
        .i_pop      (head_vld && i_instr_ready),
        .o_vld      (head_vld),
        .o_dat      (head_dat),
        .o_count    (fifo_count)
    );

    assign o_mem_address = mem_addr;
    assign o_mem_read    = mem_read;
    assign o_instr_valid = head_vld;
    assign o_instr       = head_vld ? head_dat[EW-1 -: DATA_W] : '0;
    assign o_instr_addr  = head_vld ? head_dat[ADDR_W+1 -: ADDR_W] : '0;
    assign o_instr_fault = head_vld ? head_dat[1:0] : 2'b00;

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed vector table, hand sequences, random run vs stream model.
`timescale 1ns/1ps
module tb_prefetch_unit;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0, i_flush = 1'b0, i_instr_ready = 1'b0;
    logic [31:0] i_flush_addr = '0, i_mem_data = '0;
    logic        i_mem_valid = 1'b0, i_error_not_present = 1'b0, i_error_not_user = 1'b0;
    logic [31:0] o_mem_address, o_instr, o_instr_addr;
    logic        o_mem_read, o_instr_valid;
    logic [1:0]  o_instr_fault;

    logic        w_en = 1'b0, w_flush = 1'b0, w_np = 1'b0, w_nu = 1'b0, w_rdy = 1'b0;
    logic [31:0] w_fa = '0, w_data = 32'hCAFE0001;
    logic [31:0] w_mem_address, w_instr, w_iaddr;
    logic        w_mem_read, w_mem_valid, w_ivld;
    logic [1:0]  w_fault;
    assign w_mem_valid = w_mem_read;

    always #5 i_clk = ~i_clk;

    prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
        .i_flush_addr(i_flush_addr), .o_mem_address(o_mem_address), .o_mem_read(o_mem_read),
        .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
        .i_error_not_present(i_error_not_present), .i_error_not_user(i_error_not_user),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_addr(o_instr_addr),
        .o_instr_fault(o_instr_fault), .i_instr_ready(i_instr_ready));

    prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(w_en), .i_flush(w_flush),
        .i_flush_addr(w_fa), .o_mem_address(w_mem_address), .o_mem_read(w_mem_read),
        .i_mem_valid(w_mem_valid), .i_mem_data(w_data),
        .i_error_not_present(w_np), .i_error_not_user(w_nu),
        .o_instr_valid(w_ivld), .o_instr(w_instr), .o_instr_addr(w_iaddr),
        .o_instr_fault(w_fault), .i_instr_ready(w_rdy));

    int n_checks = 0, n_fail = 0;
    bit auto_mem = 0, model_on = 0, fault_en = 0, rand_mode = 0, rdy_on_comp = 0;
    int lat = 1, wcnt = 0;
    logic [31:0] m_fetch, m_exp;
    int          m_occ, occ_seen;
    bit          m_fresh, m_halt, m_done;
    logic        prev_read, prev_comp, prev_en, prev_flush;
    logic [31:0] prev_addr;
    logic [31:0] issued[$];
    logic [31:0] popped[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [1:0] fault_fn(input logic [31:0] a);
        if (!fault_en || a[6:2] != 5'd13) return 2'b00;
        return a[7] ? 2'b10 : (a[8] ? 2'b11 : 2'b01);
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        i_enable = 0; i_flush = 0; i_instr_ready = 0;
        i_mem_valid = 0; i_error_not_present = 0; i_error_not_user = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs",
              {o_mem_read, o_mem_address, o_instr_valid, o_instr, o_instr_addr, o_instr_fault},
              {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00});
        i_rst = 1'b0;
        m_fetch = 0; m_exp = 0; m_occ = 0; occ_seen = 0;
        m_fresh = 0; m_halt = 0; m_done = 0;
        prev_read = 0; prev_comp = 0; prev_en = 0; prev_flush = 0; prev_addr = 0;
        wcnt = 0;
        issued.delete();
        popped.delete();
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic cycle();
        logic       comp, pop;
        logic [1:0] f;
        if (rand_mode) begin
            i_enable      = ($urandom_range(0, 7) != 0);
            i_instr_ready = 1'($urandom_range(0, 1));
            i_flush       = ($urandom_range(0, 23) == 0);
            i_flush_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        end
        if (auto_mem) begin
            i_error_not_present = 0; i_error_not_user = 0; i_mem_valid = 0;
            i_mem_data = $urandom;
            if (o_mem_read) begin
                if (wcnt + 1 >= lat) begin
                    f = fault_fn(o_mem_address);
                    {i_error_not_user, i_error_not_present} = f;
                    i_mem_valid = (f == 2'b00) || ($urandom_range(0, 1) == 1);
                    if (f == 2'b00) i_mem_data = mem_fn(o_mem_address);
                    wcnt = 0;
                    if (rand_mode) lat = $urandom_range(1, 3);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (rand_mode) i_mem_valid = ($urandom_range(0, 9) == 0);
            end
        end
        comp = o_mem_read && (i_mem_valid || i_error_not_present || i_error_not_user);
        if (rdy_on_comp) i_instr_ready = comp;
        pop = o_instr_valid && i_instr_ready && !i_flush;

        if (prev_read && !prev_comp) begin
            check("hold_read", o_mem_read, 1'b1);
            check("hold_addr", o_mem_address, prev_addr);
        end
        if (prev_comp) check("read_gap", o_mem_read, 1'b0);
        if (o_mem_read && !prev_read) begin
            issued.push_back(o_mem_address);
            if (model_on) begin
                check("issue_addr", o_mem_address, m_fetch);
                check("issue_allowed", prev_en && !prev_flush && !m_halt && (occ_seen < DEPTH), 1'b1);
            end
            m_fresh = 1;
        end

        if (model_on) begin
            check("instr_valid", o_instr_valid, m_occ > 0);
            if (pop) begin
                f = fault_fn(m_exp);
                popped.push_back(o_instr_addr);
                check("pop_after_fault", m_done, 1'b0);
                check("pop_addr", o_instr_addr, m_exp);
                check("pop_data", o_instr, (f == 2'b00) ? mem_fn(m_exp) : 32'h0);
                check("pop_fault", o_instr_fault, f);
                m_exp += 4;
                if (f != 2'b00) m_done = 1;
            end
            occ_seen = m_occ;
            if (i_flush) begin
                m_fetch = i_flush_addr; m_exp = i_flush_addr;
                m_occ = 0; m_fresh = 0; m_halt = 0; m_done = 0;
            end else begin
                if (comp && m_fresh) begin
                    m_occ++;
                    if (i_error_not_present || i_error_not_user) m_halt = 1;
                    else m_fetch += 4;
                end
                if (pop) m_occ--;
            end
            if (comp) m_fresh = 0;
        end

        prev_read = o_mem_read; prev_addr = o_mem_address; prev_comp = comp;
        prev_en = i_enable; prev_flush = i_flush;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    typedef struct {
        logic en, vld, nu, rdy, fl;
        logic [31:0] fa;
        logic [7:0]  dat;
        logic        rd;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ia;
        logic [7:0]  ins;
        logic [1:0]  flt;
    } vec_t;
    vec_t tbl[24];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] wq[$];
        logic        w_prev;
        bit          found;
        //           en vld nu rdy fl fa       dat      rd addr     iv ia       ins      flt
        tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h0,   0, 32'h0,   8'h00, 2'b00};
        tbl[1]  = '{1, 1, 0, 0, 0, 32'h0,   8'h11, 0, 32'h0,   1, 32'h0,   8'h11, 2'b00};
        tbl[2]  = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h4,   1, 32'h0,   8'h11, 2'b00};
        tbl[3]  = '{1, 1, 0, 1, 0, 32'h0,   8'h22, 0, 32'h4,   1, 32'h4,   8'h22, 2'b00};
        tbl[4]  = '{1, 0, 0, 1, 0, 32'h0,   8'h00, 1, 32'h8,   0, 32'h0,   8'h00, 2'b00};
        tbl[5]  = '{1, 1, 0, 1, 0, 32'h0,   8'h33, 0, 32'h8,   1, 32'h8,   8'h33, 2'b00};
        tbl[6]  = '{1, 0, 0, 1, 0, 32'h0,   8'h00, 1, 32'hC,   0, 32'h0,   8'h00, 2'b00};
        tbl[7]  = '{1, 1, 1, 0, 0, 32'h0,   8'h99, 0, 32'hC,   1, 32'hC,   8'h00, 2'b10};
        tbl[8]  = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 0, 32'hC,   1, 32'hC,   8'h00, 2'b10};
        tbl[9]  = '{1, 1, 0, 0, 0, 32'h0,   8'h00, 0, 32'hC,   1, 32'hC,   8'h00, 2'b10};
        tbl[10] = '{1, 0, 0, 1, 1, 32'h40,  8'h00, 0, 32'hC,   0, 32'h0,   8'h00, 2'b00};
        tbl[11] = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h40,  0, 32'h0,   8'h00, 2'b00};
        tbl[12] = '{0, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h40,  0, 32'h0,   8'h00, 2'b00};
        tbl[13] = '{0, 1, 0, 0, 0, 32'h0,   8'h44, 0, 32'h40,  1, 32'h40,  8'h44, 2'b00};
        tbl[14] = '{0, 0, 0, 0, 0, 32'h0,   8'h00, 0, 32'h40,  1, 32'h40,  8'h44, 2'b00};
        tbl[15] = '{1, 0, 0, 1, 1, 32'h100, 8'h00, 0, 32'h40,  0, 32'h0,   8'h00, 2'b00};
        tbl[16] = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h100, 0, 32'h0,   8'h00, 2'b00};
        tbl[17] = '{1, 0, 0, 0, 1, 32'h200, 8'h00, 1, 32'h100, 0, 32'h0,   8'h00, 2'b00};
        tbl[18] = '{1, 0, 0, 0, 1, 32'h300, 8'h00, 1, 32'h100, 0, 32'h0,   8'h00, 2'b00};
        tbl[19] = '{1, 1, 0, 0, 0, 32'h0,   8'h55, 0, 32'h100, 0, 32'h0,   8'h00, 2'b00};
        tbl[20] = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h300, 0, 32'h0,   8'h00, 2'b00};
        tbl[21] = '{1, 1, 0, 0, 1, 32'h80,  8'h66, 0, 32'h300, 0, 32'h0,   8'h00, 2'b00};
        tbl[22] = '{1, 0, 0, 0, 0, 32'h0,   8'h00, 1, 32'h80,  0, 32'h0,   8'h00, 2'b00};
        tbl[23] = '{1, 1, 0, 0, 0, 32'h0,   8'h77, 0, 32'h80,  1, 32'h80,  8'h77, 2'b00};

        // Directed vectors, inputs driven straight from the table
        do_reset();
        for (int k = 0; k < 24; k++) begin
            i_enable = tbl[k].en; i_mem_valid = tbl[k].vld; i_error_not_user = tbl[k].nu;
            i_instr_ready = tbl[k].rdy; i_flush = tbl[k].fl; i_flush_addr = tbl[k].fa;
            i_mem_data = {24'h0, tbl[k].dat};
            cycle();
            check($sformatf("vector_%0d", k),
                  {o_mem_read, o_mem_address, o_instr_valid, o_instr_addr, o_instr, o_instr_fault},
                  {tbl[k].rd, tbl[k].addr, tbl[k].iv, tbl[k].ia, {24'h0, tbl[k].ins}, tbl[k].flt});
        end

        // Queue fill with ready low, single pop, then push+pop at DEPTH-1
        do_reset();
        auto_mem = 1; model_on = 1; lat = 1;
        i_enable = 1; i_instr_ready = 0;
        repeat (30) cycle();
        check("fill_reads", issued.size(), DEPTH);
        for (int i = 0; i < issued.size(); i++) check("fill_addr", issued[i], 32'(4 * i));
        check("fill_read_idle", o_mem_read, 1'b0);
        i_instr_ready = 1; cycle(); i_instr_ready = 0;
        repeat (20) cycle();
        check("refill_reads", issued.size(), DEPTH + 1);
        if (issued.size() == DEPTH + 1) check("refill_addr", issued[DEPTH], 32'h10);
        check("refill_pops", popped.size(), 1);
        i_instr_ready = 1; cycle(); i_instr_ready = 0;
        rdy_on_comp = 1;
        repeat (12) cycle();
        rdy_on_comp = 0; i_instr_ready = 0; i_enable = 0;
        repeat (4) cycle();
        i_instr_ready = 1;
        repeat (12) cycle();
        check("drain_all", popped.size(), issued.size());
        for (int i = 0; i < popped.size(); i++) check("drain_order", popped[i], 32'(4 * i));

        // Flush with a slow read outstanding
        do_reset();
        auto_mem = 1; model_on = 1; lat = 3;
        i_enable = 1; i_instr_ready = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_mem_read && o_mem_address == 32'h8) begin found = 1; break; end
            cycle();
        end
        check("read8_seen", found, 1'b1);
        i_flush = 1; i_flush_addr = 32'h100;
        cycle();
        i_flush = 0;
        check("flush_empties", o_instr_valid, 1'b0);
        repeat (15) cycle();
        check("post_flush_issue_count", issued.size() >= 4, 1'b1);
        if (issued.size() >= 4) check("post_flush_addr", issued[3], 32'h100);
        i_instr_ready = 1;
        repeat (6) cycle();
        check("post_flush_pop", popped.size() > 0, 1'b1);
        if (popped.size() > 0) check("post_flush_first", popped[0], 32'h100);

        // Asynchronous reset during a request, stale valid afterwards
        do_reset();
        auto_mem = 1; model_on = 1; lat = 2;
        i_enable = 1; i_instr_ready = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_mem_read && issued.size() == 3) begin found = 1; break; end
            cycle();
        end
        check("req3_seen", found, 1'b1);
        #2 i_rst = 1'b1;
        #1 check("async_rst", {o_mem_read, o_instr_valid, o_mem_address}, {1'b0, 1'b0, 32'h0});
        do_reset();
        auto_mem = 0; i_enable = 0; i_mem_valid = 1; i_mem_data = 32'hDEAD_BEEF;
        repeat (2) cycle();
        check("stale_valid_ignored", {o_instr_valid, o_mem_read}, 2'b00);
        i_mem_valid = 0;

        // Wrap-around from the top of the address space
        w_prev = 0;
        w_en = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            if (w_mem_read && !w_prev) wq.push_back(w_mem_address);
            w_prev = w_mem_read;
        end
        w_en = 0;
        check("wrap_reads", wq.size() >= 2, 1'b1);
        if (wq.size() >= 2) begin
            check("wrap_first", wq[0], 32'hFFFF_FFFC);
            check("wrap_second", wq[1], 32'h0);
        end
        check("wrap_head", {w_ivld, w_iaddr, w_instr, w_fault}, {1'b1, 32'hFFFF_FFFC, 32'hCAFE0001, 2'b00});

        // Random traffic against the stream model
        do_reset();
        auto_mem = 1; model_on = 1; fault_en = 1; rand_mode = 1; lat = 1;
        repeat (3000) cycle();
        rand_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
